// File: rtl/jpeg_zz_pkg.sv
// Shared zigzag/raster index tables for the JPEG 8x8 coefficient reorder blocks.
// ZZ2R maps a zigzag scan position to its raster (row*8+col) position; R2Z is the inverse.
package jpeg_zz_pkg;

  localparam int BLK_SZ = 64;

  localparam logic [5:0] ZZ2R [BLK_SZ] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [5:0] R2Z [BLK_SZ] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

endpackage

// File: rtl/jpeg_zz_addr_rom.sv
// Combinational zigzag-to-raster address lookup used by the inverse zigzag write path.
module jpeg_zz_addr_rom
  import jpeg_zz_pkg::*;
(
  input  logic [5:0] zz_idx,
  output logic [5:0] raster_idx
);

  assign raster_idx = ZZ2R[zz_idx];

endmodule

// File: rtl/jpeg_izigzag.sv
// Inverse zigzag reorder: zigzag-ordered coefficients in, raster-ordered out.
// Two 64-entry register banks ping-pong so one block fills while the other drains.
module jpeg_izigzag
  import jpeg_zz_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [5:0]    out_idx,
  output logic          out_last
);

  logic [DW-1:0] mem [2][BLK_SZ];
  logic [5:0]    wcnt, rcnt, waddr;
  logic          wb, rb;
  logic [1:0]    full, full_nxt;
  logic          wr_fire, rd_fire, wr_done, rd_done;

  jpeg_zz_addr_rom u_addr_rom (
    .zz_idx     (wcnt),
    .raster_idx (waddr)
  );

  assign in_ready  = !full[wb];
  assign out_valid = full[rb];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_done   = wr_fire && (wcnt == 6'd63);
  assign rd_done   = rd_fire && (rcnt == 6'd63);

  // Write and read completions always hit opposite banks, so both updates can apply.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wb] = 1'b1;
    if (rd_done) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
      rcnt <= '0;
      wb   <= 1'b0;
      rb   <= 1'b0;
      full <= '0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wcnt <= wcnt + 6'd1;
        if (wr_done) wb <= ~wb;
      end
      if (rd_fire) begin
        rcnt <= rcnt + 6'd1;
        if (rd_done) rb <= ~rb;
      end
    end
  end

  // Coefficient storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wb][waddr] <= in_data;
  end

  assign out_data = out_valid ? mem[rb][rcnt] : '0;
  assign out_idx  = rcnt;
  assign out_last = (rcnt == 6'd63);

endmodule

// File: tb/tb_jpeg_izigzag.sv
// Directed and randomized checks of the inverse zigzag reorder against an independent scoreboard.
module tb_jpeg_izigzag;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [5:0]    out_idx;
  logic          out_last;

  jpeg_izigzag #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Raster position -> zigzag position, written out independently of the RTL package.
  int r2z [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  typedef struct {
    int idx;
    int zz;
    bit last;
  } ord_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [5:0]    idx;
    logic          last;
  } exp_t;

  ord_t ord_tab [8];

  logic [DW-1:0] in_q [$];
  logic [DW-1:0] pend [$];
  exp_t          exp_q [$];

  logic [DW-1:0] got_data [64];
  logic          got_last [64];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int n_in = 0;
  int n_out = 0;
  int n_valid = 0;
  int last_in_cyc = -1;
  int first_valid_cyc = -1;
  int first_out_cyc = -1;
  int last_out_cyc = -1;

  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic [5:0]    hold_idx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    in_q.delete();
    pend.delete();
    exp_q.delete();
    hold_pend = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    exp_t e;
    in_q.push_back(d);
    pend.push_back(d);
    if (pend.size() == 64) begin
      for (int r = 0; r < 64; r++) begin
        e.data = pend[r2z[r]];
        e.idx  = 6'(r);
        e.last = (r == 63);
        exp_q.push_back(e);
      end
      pend.delete();
    end
  endtask

  // Called just after a rising edge; drives, samples, then advances one clock.
  task automatic cycle(input bit iv_en, input bit or_en);
    logic ifire, ofire;
    exp_t e;
    in_valid  = iv_en && (in_q.size() > 0);
    in_data   = in_valid ? in_q[0] : '0;
    out_ready = or_en;
    #1;
    if (hold_pend) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(hold_data));
      check("hold_idx", 32'(out_idx), 32'(hold_idx));
    end
    if (!out_valid) check("idle_data_zero", 32'(out_data), 32'd0);
    ifire = in_valid && in_ready;
    ofire = out_valid && out_ready;
    if (out_valid) begin
      n_valid++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (ofire) begin
      n_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      got_data[out_idx] = out_data;
      got_last[out_idx] = out_last;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_idx", 32'(out_idx), 32'(e.idx));
        check("out_last", 32'(out_last), 32'(e.last));
      end
    end
    hold_pend = out_valid && !out_ready;
    hold_data = out_data;
    hold_idx  = out_idx;
    @(posedge clk);
    cyc++;
    if (ifire) begin
      void'(in_q.pop_front());
      n_in++;
      last_in_cyc = cyc;
    end
    #1;
  endtask

  task automatic drain(input int max_cyc, input bit rnd);
    int n;
    n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
      if (rnd) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else     cycle(1'b1, 1'b1);
      n++;
    end
    check("drain_done", 32'(in_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_table(input string tag, input int base);
    for (int t = 0; t < 8; t++) begin
      check({tag, "_data"}, 32'(got_data[ord_tab[t].idx]), 32'(base + ord_tab[t].zz));
      check({tag, "_last"}, 32'(got_last[ord_tab[t].idx]), 32'(ord_tab[t].last));
    end
  endtask

  initial begin
    int base_in, base_out, base_valid;

    ord_tab[0] = '{idx: 0,  zz: 0,  last: 1'b0};
    ord_tab[1] = '{idx: 1,  zz: 1,  last: 1'b0};
    ord_tab[2] = '{idx: 2,  zz: 5,  last: 1'b0};
    ord_tab[3] = '{idx: 8,  zz: 2,  last: 1'b0};
    ord_tab[4] = '{idx: 16, zz: 3,  last: 1'b0};
    ord_tab[5] = '{idx: 9,  zz: 4,  last: 1'b0};
    ord_tab[6] = '{idx: 7,  zz: 28, last: 1'b0};
    ord_tab[7] = '{idx: 63, zz: 63, last: 1'b1};

    // Reset values
    rst = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    do_reset();

    // Ordering and latency: data = zigzag position
    for (int k = 0; k < 64; k++) push_word(DW'(k));
    first_valid_cyc = -1;
    base_valid = n_valid;
    repeat (64) cycle(1'b1, 1'b1);
    check("ord_inputs", 32'(n_in), 32'd64);
    repeat (70) cycle(1'b1, 1'b1);
    check("latency", 32'(first_valid_cyc), 32'(last_in_cyc));
    check("valid_run", 32'(n_valid - base_valid), 32'd64);
    check("ord_idle_after", 32'(out_valid), 32'd0);
    check("ord_exp_empty", 32'(exp_q.size()), 32'd0);
    check_table("ord", 0);

    // Back-pressure: two banks fill, then in_ready drops
    do_reset();
    for (int k = 0; k < 130; k++) push_word(DW'(12'h300 + k));
    base_in = n_in;
    repeat (140) cycle(1'b1, 1'b0);
    check("bp_accepts", 32'(n_in - base_in), 32'd128);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_idx", 32'(out_idx), 32'd0);
    check("bp_out_data", 32'(out_data), 32'(exp_q[0].data));
    for (int i = 0; i < 64; i++) begin
      check("bp_ready_low", 32'(in_ready), 32'd0);
      cycle(1'b0, 1'b1);
    end
    check("bp_ready_back", 32'(in_ready), 32'd1);
    drain(300, 1'b0);
    check("bp_partial_pending", 32'(out_valid), 32'd0);

    // Streaming: four back-to-back blocks, no bubbles
    do_reset();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 64; k++) push_word(DW'(b * 64 + k));
    base_in = n_in;
    base_out = n_out;
    first_out_cyc = -1;
    repeat (256) cycle(1'b1, 1'b1);
    check("stream_in_rate", 32'(n_in - base_in), 32'd256);
    drain(300, 1'b0);
    check("stream_out_count", 32'(n_out - base_out), 32'd256);
    check("stream_out_span", 32'(last_out_cyc - first_out_cyc), 32'd255);

    // Random stalls over 20 blocks
    do_reset();
    for (int b = 0; b < 20; b++)
      for (int k = 0; k < 64; k++) push_word(DW'($urandom_range(0, 4095)));
    base_out = n_out;
    drain(20000, 1'b1);
    check("rand_out_count", 32'(n_out - base_out), 32'd1280);

    // Reset mid-block while the previous block is half read
    do_reset();
    for (int k = 0; k < 64; k++) push_word(DW'(12'h400 + k));
    repeat (64) cycle(1'b1, 1'b0);
    for (int k = 0; k < 30; k++) push_word(DW'(12'h500 + k));
    repeat (32) cycle(1'b1, 1'b1);
    check("mid_valid_before", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_idx", 32'(out_idx), 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 64; k++) push_word(DW'(12'h600 + k));
    drain(300, 1'b0);
    check_table("mid", 12'h600);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/jpeg_izigzag.md
Name: jpeg_izigzag

Overview:
- Inverse zigzag reorder for the JPEG decode path. It is the receiving-side counterpart of the encoder's zigzag module.
- Accepts 64 quantized coefficients per 8x8 block in zigzag scan order and emits them in raster (row-major) order.
- Sits between the entropy/dequant stage and the inverse DCT.
- Uses a ping-pong register buffer so one block can be written while the previous one is read.

Parameters:
- DW, 12, coefficient width in bits (signed two's-complement, passed through unmodified).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  input can be accepted.
- in_data  in  DW  coefficient, zigzag order.
- out_valid  out  1  output coefficient valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DW  coefficient, raster order.
- out_idx  out  6  raster index of out_data (row*8+col).
- out_last  out  1  high with out_idx==63.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low on rst.
  - Reset clears wcnt, rcnt, wb, rb and full[1:0] to 0.
  - Buffer contents are not reset.
- Output values in and after reset:
  - in_ready=1, out_valid=0, out_idx=0, out_last=0.
  - out_data is forced to 0 whenever out_valid=0.
- Storage: two banks of 64 x DW flops, bank[wb] for writing and bank[rb] for reading.
- Input handshake and write path:
  - Input transfer occurs on in_valid && in_ready.
  - The transfer writes bank[wb][ZZ2R[wcnt]] = in_data and increments wcnt.
  - in_ready = !full[wb], combinational from state only and never from in_valid.
  - On transfer with wcnt==63: full[wb] is set, wb toggles and wcnt wraps to 0.
- Output handshake and read path:
  - out_valid = full[rb].
  - out_data = bank[rb][rcnt], out_idx = rcnt, out_last = (rcnt==63).
  - Output transfer occurs on out_valid && out_ready and increments rcnt.
  - On transfer with rcnt==63: full[rb] is cleared, rb toggles and rcnt wraps to 0.
- Latency: if the 64th input is accepted at edge N, out_valid=1 with out_idx=0 is visible after edge N (same cycle as wcnt wraps).
- Throughput: 1 coefficient/cycle sustained in both directions.
- Simultaneous events:
  - A write completion and a read completion in the same cycle always target different banks, because a write requires !full and a read requires full.
  - Both full updates apply independently.
- Full and empty conditions:
  - Both banks full: in_ready=0 until a read completion frees bank rb.
  - Both banks empty: out_valid=0.
- Partial blocks: no timeout and no flush. A partial block stays pending until 64 coefficients arrive or reset.
- Reset mid-operation: any partial input block and any unread output block are discarded. After release the first input is treated as zigzag index 0.
- out_valid, once high, holds with stable out_data/out_idx until transferred; it is never retracted.
- Arithmetic: no arithmetic on the data path. Counters are 6-bit with natural wrap.

Decomposition:
- Shared package jpeg_zz_pkg holds:
  - localparam BLK_SZ=64;
  - the 64-entry ZZ2R table (zigzag index -> raster index: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,...,62,63);
  - the R2Z inverse table, which is reused by the encoder-side checks.
- One sub-module: jpeg_zz_addr_rom, a combinational 6-bit -> 6-bit lookup on ZZ2R that the write path instantiates.

Test Plan:
- Ordering: reset, then feed one block with in_data=k for k=0..63 and out_ready=1. Required: out_idx=0 data 0, idx 1 data 1, idx 2 data 5, idx 8 data 2, idx 16 data 3, idx 63 data 63 with out_last=1.
- Latency: the 64th input accepted at edge N gives out_valid=1 after edge N, with a total of 64 consecutive valid output cycles.
- Back-pressure: hold out_ready=0 and stream 130 inputs. Required: in_ready drops after exactly 128 accepts; out_data/out_idx stay stable at idx 0. Releasing out_ready for 64 cycles re-asserts in_ready after block 0's last transfer.
- Streaming: 4 back-to-back blocks with data = block*64+k and both sides always ready. Required: no bubbles after the first block, and every block is reordered correctly.
- Random stalls: randomize in_valid/out_ready at 50% over 20 blocks. The scoreboard applies R2Z and requires an exact match with no drops or duplicates.
- Reset mid-block: assert rst after 30 inputs of block 1 while block 0 is half read. Required: out_valid=0 and in_ready=1 immediately. The next full block is reordered from index 0.
